// File: rtl/guess_round_sched_if.sv
// Guess handshake bundle between the key-entry block and the round scheduler.
//
// Handshake: a guess transfers on a rising clock edge where guess_vld and
// guess_rdy are both high. guess is only meaningful while guess_vld is high.
// The sender need not wait for guess_rdy before raising guess_vld. A guess
// offered while guess_rdy is low is dropped, not held for later.
//
// Signals:
//   guess_vld  key-entry -> scheduler  guess strobe
//   guess      key-entry -> scheduler  8-bit guess value
//   guess_rdy  scheduler -> key-entry  scheduler can take a guess this cycle
interface guess_round_sched_if;
    logic       guess_vld;
    logic [7:0] guess;
    logic       guess_rdy;

    modport master (output guess_vld, output guess, input guess_rdy);
    modport slave  (input guess_vld, input guess, output guess_rdy);
endinterface

// File: rtl/guess_round_sched.sv
// Round controller for the number-guessing datapath.
// It runs the random generator, latches a clamped secret target, and takes
// guesses over the guess handshake. Each guess is judged against the
// target. The controller then narrows the legal range [ll,hl], counts down
// the remaining attempts, and declares win or lose.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        begin or abort a round (a new assertion is required)
//   target       random value, sampled on the last SEED cycle
//   gif          guess handshake (slave side)
//   genrand      random generator advance enable
//   ll, hl       current inclusive bounds
//   tries_left   remaining attempts
//   hint_lt/gt   one-cycle pulses: guess below/above target
//   outrange     one-cycle pulse: guess outside [ll,hl]
//   win, lose    round result levels
//   busy         round in progress (SEED, WAIT, CHECK)
//   score        rounds won, saturating at 255
//   state_dbg    current FSM state, for debug/observation
module guess_round_sched #(
    parameter int MAX_TRIES   = 7,
    parameter int SEED_CYCLES = 16,
    parameter int LO          = 1,
    parameter int HI          = 99
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                target,
    guess_round_sched_if.slave        gif,
    output logic                      genrand,
    output logic [7:0]                ll,
    output logic [7:0]                hl,
    output logic [3:0]                tries_left,
    output logic                      hint_lt,
    output logic                      hint_gt,
    output logic                      outrange,
    output logic                      win,
    output logic                      lose,
    output logic                      busy,
    output logic [7:0]                score,
    output logic [2:0]                state_dbg
);
    localparam logic [7:0] LO_V      = 8'(LO);
    localparam logic [7:0] HI_V      = 8'(HI);
    localparam logic [3:0] TRIES_V   = 4'(MAX_TRIES);
    localparam logic [7:0] SEED_LAST = 8'(SEED_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_WAIT, S_CHECK, S_WIN, S_LOSE
    } state_t;

    state_t     state, state_n;
    logic [7:0] seed_cnt, seed_cnt_n;
    logic [7:0] tgt, tgt_n;
    logic [7:0] gss, gss_n;
    logic [7:0] ll_n, hl_n, score_n;
    logic [3:0] tries_n, tries_dec;
    logic       hint_lt_n, hint_gt_n, outrange_n, win_n, lose_n;
    logic       start_q, start_evt;

    // A round starts only on a fresh assertion of start. If start is held
    // high, it begins one round and does not keep restarting SEED.
    assign start_evt = start && !start_q;
    assign tries_dec = tries_left - 4'd1;

    assign gif.guess_rdy = (state == S_WAIT);
    assign busy          = (state == S_SEED) || (state == S_WAIT) || (state == S_CHECK);
    assign state_dbg     = state;

    always_comb begin
        state_n    = state;
        seed_cnt_n = seed_cnt;
        tgt_n      = tgt;
        gss_n      = gss;
        ll_n       = ll;
        hl_n       = hl;
        tries_n    = tries_left;
        hint_lt_n  = 1'b0;
        hint_gt_n  = 1'b0;
        outrange_n = 1'b0;
        win_n      = win;
        lose_n     = lose;
        score_n    = score;
        if (start_evt) begin
            // Start from IDLE/WIN/LOSE, or abort a busy round. Any guess in
            // CHECK this cycle is discarded.
            state_n    = S_SEED;
            seed_cnt_n = 8'd0;
            ll_n       = LO_V;
            hl_n       = HI_V;
            tries_n    = TRIES_V;
            win_n      = 1'b0;
            lose_n     = 1'b0;
        end else begin
            case (state)
                S_SEED: begin
                    if (seed_cnt == SEED_LAST) begin
                        state_n = S_WAIT;
                        if (target < LO_V)      tgt_n = LO_V;
                        else if (target > HI_V) tgt_n = HI_V;
                        else                    tgt_n = target;
                    end else begin
                        seed_cnt_n = seed_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (gif.guess_vld) begin
                        gss_n   = gif.guess;
                        state_n = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (gss < ll || gss > hl) begin
                        outrange_n = 1'b1;
                        state_n    = S_WAIT;
                    end else if (gss == tgt) begin
                        state_n = S_WIN;
                        win_n   = 1'b1;
                        if (score != 8'hFF) score_n = score + 8'd1;
                    end else begin
                        // ll <= tgt <= hl, so these adjustments cannot wrap.
                        if (gss < tgt) begin
                            hint_lt_n = 1'b1;
                            ll_n      = gss + 8'd1;
                        end else begin
                            hint_gt_n = 1'b1;
                            hl_n      = gss - 8'd1;
                        end
                        tries_n = tries_dec;
                        if (tries_dec == 4'd0) begin
                            state_n = S_LOSE;
                            lose_n  = 1'b1;
                        end else begin
                            state_n = S_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            seed_cnt   <= 8'd0;
            tgt        <= LO_V;
            gss        <= 8'd0;
            ll         <= LO_V;
            hl         <= HI_V;
            tries_left <= TRIES_V;
            hint_lt    <= 1'b0;
            hint_gt    <= 1'b0;
            outrange   <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            score      <= 8'd0;
            genrand    <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state      <= state_n;
            seed_cnt   <= seed_cnt_n;
            tgt        <= tgt_n;
            gss        <= gss_n;
            ll         <= ll_n;
            hl         <= hl_n;
            tries_left <= tries_n;
            hint_lt    <= hint_lt_n;
            hint_gt    <= hint_gt_n;
            outrange   <= outrange_n;
            win        <= win_n;
            lose       <= lose_n;
            score      <= score_n;
            // genrand is registered, so it is high during exactly the SEED cycles.
            genrand    <= (state_n == S_SEED);
            start_q    <= start;
        end
    end
endmodule

// File: tb/tb_guess_round_sched.sv
module tb_guess_round_sched;
    logic       clk, rst, start;
    logic [7:0] target;
    logic       genrand, hint_lt, hint_gt, outrange, win, lose, busy;
    logic [7:0] ll, hl, score;
    logic [3:0] tries_left;
    logic [2:0] state_dbg;
    logic [4:0] flags;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model of the round
    int m_ll, m_hl, m_tries, m_tgt, m_score;
    bit m_win, m_lose, m_lt, m_gt, m_or;

    guess_round_sched_if gif();

    guess_round_sched dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .gif(gif),
        .genrand(genrand), .ll(ll), .hl(hl), .tries_left(tries_left),
        .hint_lt(hint_lt), .hint_gt(hint_gt), .outrange(outrange),
        .win(win), .lose(lose), .busy(busy), .score(score), .state_dbg(state_dbg)
    );

    assign flags = {hint_lt, hint_gt, outrange, win, lose};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model
    task automatic model_new_round(input int tval);
        m_tgt   = (tval < 1) ? 1 : (tval > 99) ? 99 : tval;
        m_ll    = 1;
        m_hl    = 99;
        m_tries = 7;
        m_win   = 0;
        m_lose  = 0;
        m_lt = 0; m_gt = 0; m_or = 0;
    endtask

    task automatic model_guess(input int g);
        m_lt = 0; m_gt = 0; m_or = 0;
        if (g < m_ll || g > m_hl) m_or = 1;
        else if (g == m_tgt) begin
            m_win = 1;
            if (m_score < 255) m_score++;
        end else begin
            if (g < m_tgt) begin m_lt = 1; m_ll = g + 1; end
            else           begin m_gt = 1; m_hl = g - 1; end
            m_tries--;
            if (m_tries == 0) m_lose = 1;
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(output int gcnt);
        int i;
        gcnt = 0;
        for (i = 0; i < 300; i++) begin
            if (gif.guess_rdy) break;
            if (genrand) gcnt++;
            tick();
        end
        if (i == 300) begin
            n_checks++;
            $display("FAIL wait_rdy_timeout: guess_rdy=%0d required 1", gif.guess_rdy);
        end
    endtask

    task automatic start_round(input int tval, output int gcnt);
        target = 8'(tval);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        model_new_round(tval);
        wait_rdy(gcnt);
    endtask

    task automatic do_guess(input int g);
        gif.guess_vld = 1'b1;
        gif.guess     = 8'(g);
        tick();
        gif.guess_vld = 1'b0;
        tick();
        model_guess(g);
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; target = 8'd0;
        gif.guess_vld = 1'b0; gif.guess = 8'd0;
        m_score = 0;
        repeat (3) tick();
        n_checks++; if ({genrand, gif.guess_rdy, busy} !== 3'b000) $display("FAIL rst_ctl: got %b required 000", {genrand, gif.guess_rdy, busy}); else n_pass++;
        n_checks++; if ({ll, hl} !== {8'd1, 8'd99}) $display("FAIL rst_bounds: got %0d/%0d required 1/99", ll, hl); else n_pass++;
        n_checks++; if (tries_left !== 4'd7) $display("FAIL rst_tries: got %0d required 7", tries_left); else n_pass++;
        n_checks++; if ({flags, score} !== 13'd0) $display("FAIL rst_flags_score: got %b/%0d required 0/0", flags, score); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_seed_clamp();
        int gc;
        start_round(120, gc);
        n_checks++; if (gc !== 16) $display("FAIL seed_len: got %0d required 16", gc); else n_pass++;
        n_checks++; if ({genrand, busy} !== 2'b01) $display("FAIL seed_wait_ctl: got %b required 01", {genrand, busy}); else n_pass++;
        do_guess(99);
        n_checks++; if ({flags, score} !== {5'b00010, 8'(m_score)}) $display("FAIL clamp_hi: got %b/%0d required 00010/%0d", flags, score, m_score); else n_pass++;
        start_round(0, gc);
        do_guess(1);
        n_checks++; if ({flags, score} !== {5'b00010, 8'(m_score)}) $display("FAIL clamp_lo: got %b/%0d required 00010/%0d", flags, score, m_score); else n_pass++;
    endtask

    task automatic test_basic_win();
        int gc;
        start_round(42, gc);
        do_guess(50);
        n_checks++; if ({flags, hl, tries_left} !== {5'b01000, 8'd49, 4'd6}) $display("FAIL win_g1: got %b/%0d/%0d required 01000/49/6", flags, hl, tries_left); else n_pass++;
        do_guess(30);
        n_checks++; if ({flags, ll, tries_left} !== {5'b10000, 8'd31, 4'd5}) $display("FAIL win_g2: got %b/%0d/%0d required 10000/31/5", flags, ll, tries_left); else n_pass++;
        do_guess(42);
        n_checks++; if ({flags, busy, score} !== {5'b00010, 1'b0, 8'(m_score)}) $display("FAIL win_g3: got %b/%0d/%0d required 00010/0/%0d", flags, busy, score, m_score); else n_pass++;
    endtask

    task automatic test_lose();
        int gc;
        int sc;
        start_round(10, gc);
        sc = m_score;
        for (int i = 0; i < 7; i++) begin
            do_guess(90 - 10 * i);
            n_checks++; if (hint_gt !== 1'b1) $display("FAIL lose_hint_gt%0d: got %0d required 1", i, hint_gt); else n_pass++;
        end
        n_checks++; if ({hl, tries_left, lose, win} !== {8'd29, 4'd0, 1'b1, 1'b0}) $display("FAIL lose_end: got hl=%0d tries=%0d lose=%0d win=%0d required 29/0/1/0", hl, tries_left, lose, win); else n_pass++;
        n_checks++; if (score !== 8'(sc)) $display("FAIL lose_score: got %0d required %0d", score, sc); else n_pass++;
        repeat (3) tick();
        n_checks++; if ({lose, busy, hl} !== {1'b1, 1'b0, 8'd29}) $display("FAIL lose_hold: got %b required 1_0_29", {lose, busy, hl}); else n_pass++;
    endtask

    task automatic test_outrange();
        int gc;
        start_round(60, gc);
        do_guess(70);
        n_checks++; if ({hl, tries_left} !== {8'd69, 4'd6}) $display("FAIL or_g1: got %0d/%0d required 69/6", hl, tries_left); else n_pass++;
        do_guess(75);
        n_checks++; if ({flags, tries_left, hl, gif.guess_rdy} !== {5'b00100, 4'd6, 8'd69, 1'b1}) $display("FAIL or_g2: got %b/%0d/%0d/%0d required 00100/6/69/1", flags, tries_left, hl, gif.guess_rdy); else n_pass++;
        do_guess(69);
        n_checks++; if ({flags, hl, tries_left} !== {5'b01000, 8'd68, 4'd5}) $display("FAIL or_edge_hl: got %b/%0d/%0d required 01000/68/5", flags, hl, tries_left); else n_pass++;
    endtask

    task automatic test_abort();
        int gc;
        int sc;
        start_round(50, gc);
        sc = m_score;
        do_guess(60);
        do_guess(40);
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_round(50);
        n_checks++; if ({tries_left, ll, hl, score} !== {4'd7, 8'd1, 8'd99, 8'(sc)}) $display("FAIL abort_wait: got %0d/%0d/%0d/%0d required 7/1/99/%0d", tries_left, ll, hl, score, sc); else n_pass++;
        n_checks++; if ({busy, genrand, gif.guess_rdy} !== 3'b110) $display("FAIL abort_seed: got %b required 110", {busy, genrand, gif.guess_rdy}); else n_pass++;
        wait_rdy(gc);
        // abort while the guess sits in CHECK: it must be discarded
        gif.guess_vld = 1'b1; gif.guess = 8'd20;
        tick();
        gif.guess_vld = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({flags, tries_left, ll, score} !== {5'b00000, 4'd7, 8'd1, 8'(sc)}) $display("FAIL abort_check: got %b/%0d/%0d/%0d required 00000/7/1/%0d", flags, tries_left, ll, score, sc); else n_pass++;
        wait_rdy(gc);
        do_guess(50);
        n_checks++; if ({win, score} !== {1'b1, 8'(m_score)}) $display("FAIL abort_then_win: got %0d/%0d required 1/%0d", win, score, m_score); else n_pass++;
    endtask

    task automatic test_start_held();
        int gc;
        target = 8'd33;
        start  = 1'b1;
        tick();
        model_new_round(33);
        wait_rdy(gc);
        n_checks++; if (gc !== 16) $display("FAIL held_seed_len: got %0d required 16", gc); else n_pass++;
        do_guess(33);
        repeat (5) tick();
        n_checks++; if ({win, busy, genrand, score} !== {3'b100, 8'(m_score)}) $display("FAIL held_one_round: got %b/%0d required 100/%0d", {win, busy, genrand}, score, m_score); else n_pass++;
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int gc;
        int g;
        int errs;
        errs = 0;
        for (int r = 0; r < 20; r++) begin
            start_round($urandom_range(0, 255), gc);
            for (int k = 0; k < 25 && !m_win && !m_lose; k++) begin
                if ($urandom_range(0, 9) < 7) g = $urandom_range(m_ll, m_hl);
                else                          g = $urandom_range(0, 255);
                do_guess(g);
                n_checks++;
                if ({flags, ll, hl, tries_left, score, gif.guess_rdy} !==
                    {m_lt, m_gt, m_or, m_win, m_lose, 8'(m_ll), 8'(m_hl), 4'(m_tries), 8'(m_score), !(m_win || m_lose)}) begin
                    if (errs < 10) $display("FAIL rand_r%0d_g%0d: got f=%b ll=%0d hl=%0d t=%0d s=%0d rdy=%0d required f=%b%b%b%b%b ll=%0d hl=%0d t=%0d s=%0d",
                        r, g, flags, ll, hl, tries_left, score, gif.guess_rdy,
                        m_lt, m_gt, m_or, m_win, m_lose, m_ll, m_hl, m_tries, m_score);
                    errs++;
                end else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        int gc;
        while (m_score < 255) begin
            start_round(77, gc);
            do_guess(77);
        end
        n_checks++; if (score !== 8'd255) $display("FAIL sat_reach: got %0d required 255", score); else n_pass++;
        start_round(77, gc);
        do_guess(77);
        n_checks++; if ({win, score} !== {1'b1, 8'd255}) $display("FAIL sat_hold: got %0d/%0d required 1/255", win, score); else n_pass++;
    endtask

    task automatic test_async_reset();
        int gc;
        // guesses offered during SEED must be ignored
        target = 8'd40;
        start  = 1'b1;
        tick();
        start = 1'b0;
        model_new_round(40);
        gif.guess_vld = 1'b1; gif.guess = 8'd5;
        repeat (5) tick();
        gif.guess_vld = 1'b0;
        wait_rdy(gc);
        repeat (3) tick();
        n_checks++; if ({gif.guess_rdy, flags, tries_left, ll} !== {1'b1, 5'b00000, 4'd7, 8'd1}) $display("FAIL seed_vld_ignored: got %b/%b/%0d/%0d required 1/00000/7/1", gif.guess_rdy, flags, tries_left, ll); else n_pass++;
        do_guess(60);
        // reset lands mid-CHECK, checked before any further edge
        gif.guess_vld = 1'b1; gif.guess = 8'd20;
        tick();
        gif.guess_vld = 1'b0;
        rst = 1'b0;
        #1;
        m_score = 0;
        n_checks++; if ({genrand, gif.guess_rdy, busy, flags} !== 8'd0) $display("FAIL arst_ctl: got %b required 00000000", {genrand, gif.guess_rdy, busy, flags}); else n_pass++;
        n_checks++; if ({ll, hl, tries_left, score} !== {8'd1, 8'd99, 4'd7, 8'd0}) $display("FAIL arst_vals: got %0d/%0d/%0d/%0d required 1/99/7/0", ll, hl, tries_left, score); else n_pass++;
        #10;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_seed_clamp();
        test_basic_win();
        test_lose();
        test_outrange();
        test_abort();
        test_start_held();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1);
    end
endmodule
